// File: rtl/spi_bus_pkg.sv
// Shared definitions for the SPI bus arbiter: master indices, FSM encoding
// and small index helpers used by the arbiter and its round-robin picker.
package spi_bus_pkg;

    localparam int N_MASTERS = 3;

    localparam logic [1:0] AMP = 2'd0;
    localparam logic [1:0] ADC = 2'd1;
    localparam logic [1:0] DAC = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        GUARD = 2'd2
    } arb_state_e;

    // Wraps DAC back to AMP so the round-robin pointer always stays in 0..2.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == DAC) ? AMP : idx + 2'd1;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = AMP;
        if (oh[ADC]) idx = ADC;
        if (oh[DAC]) idx = DAC;
        return idx;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_pick3.sv
// Combinational round-robin picker for three requesters: scans upward from
// ptr_i (modulo 3) and returns the first requester as a one-hot vector.
module rr_pick3
    import spi_bus_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] grant_next_o,
    output logic       valid_o
);

    int   slot;
    logic found;

    // An out-of-range pointer (3) folds onto 0 through the modulo.
    always_comb begin
        grant_next_o = '0;
        found        = 1'b0;
        slot         = 0;
        for (int k = 0; k < N_MASTERS; k++) begin
            slot = (int'(ptr_i) + k) % N_MASTERS;
            if (!found && req_i[slot]) begin
                grant_next_o[slot] = 1'b1;
                found              = 1'b1;
            end
        end
    end

    assign valid_o = found;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared board SPI bus for the preamp, ADC and DAC
// masters, with an idle guard gap between owners and a hang timeout.
module spi_bus_arbiter
    import spi_bus_pkg::*;
#(
    parameter int GUARD_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       CLK50MHZ,
    input  logic       RST,
    input  logic [2:0] req,
    input  logic [2:0] done,
    input  logic [2:0] m_sck,
    input  logic [2:0] m_mosi,
    input  logic [2:0] m_sel,
    output logic [2:0] grant,
    output logic       busy,
    output logic       timeout,
    output logic [1:0] timeout_id,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       m_miso,
    output logic       amp_cs_n,
    output logic       ad_conv,
    output logic       dac_cs_n,
    output logic       spi_ss_b,
    output logic       sf_ce0
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  GUARD_LAST   = 8'(GUARD_CYCLES - 1);

    arb_state_e  state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  rr_q, rr_d;
    logic [15:0] own_cnt_q, own_cnt_d;
    logic [7:0]  guard_cnt_q, guard_cnt_d;
    logic        timeout_q, timeout_d;
    logic [1:0]  timeout_id_q, timeout_id_d;

    logic [2:0]  pick_grant;
    logic        pick_valid;
    logic        owner_done;
    logic        owner_req;
    logic        expired;

    rr_pick3 u_pick (
        .req_i        (req),
        .ptr_i        (rr_q),
        .grant_next_o (pick_grant),
        .valid_o      (pick_valid)
    );

    // Masking with the one-hot grant makes non-owner done/req invisible here.
    assign owner_done = |(done & grant_q);
    assign owner_req  = |(req & grant_q);
    assign expired    = (own_cnt_q == TIMEOUT_LAST);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        own_cnt_d    = own_cnt_q;
        guard_cnt_d  = guard_cnt_q;
        timeout_d    = 1'b0;
        timeout_id_d = timeout_id_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d   = pick_grant;
                    owner_d   = onehot_to_idx(pick_grant);
                    own_cnt_d = '0;
                    state_d   = OWNED;
                end
            end
            OWNED: begin
                if (owner_done || !owner_req || expired) begin
                    grant_d     = '0;
                    rr_d        = next_idx(owner_q);
                    guard_cnt_d = '0;
                    state_d     = GUARD;
                    // A clean finish on the last allowed cycle is not a hang.
                    if (!owner_done && owner_req) begin
                        timeout_d    = 1'b1;
                        timeout_id_d = owner_q;
                    end
                end else begin
                    own_cnt_d = own_cnt_q + 16'd1;
                end
            end
            GUARD: begin
                if (guard_cnt_q == GUARD_LAST) begin
                    state_d = IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= AMP;
            rr_q         <= AMP;
            own_cnt_q    <= '0;
            guard_cnt_q  <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            own_cnt_q    <= own_cnt_d;
            guard_cnt_q  <= guard_cnt_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = (state_q != IDLE);
    assign timeout    = timeout_q;
    assign timeout_id = timeout_id_q;

    // Bus mux is driven straight from the grant register, so an empty grant
    // parks every line at its idle level during guard and idle.
    assign spi_sck  = |(grant_q & m_sck);
    assign spi_mosi = |(grant_q & m_mosi);
    assign amp_cs_n = ~(grant_q[AMP] & m_sel[AMP]);
    assign ad_conv  = grant_q[ADC] & m_sel[ADC];
    assign dac_cs_n = ~(grant_q[DAC] & m_sel[DAC]);

    assign m_miso   = spi_miso;
    assign spi_ss_b = 1'b1;
    assign sf_ce0   = 1'b1;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: directed corner sequences, a
// vector table for the bus mux and randomized traffic against a reference model.
module tb_spi_bus_arbiter;

    localparam int GUARD = 2;
    localparam int TMO   = 16;

    logic       CLK50MHZ = 1'b0;
    logic       RST      = 1'b1;
    logic [2:0] req      = '0;
    logic [2:0] done     = '0;
    logic [2:0] m_sck    = '0;
    logic [2:0] m_mosi   = '0;
    logic [2:0] m_sel    = '0;
    logic       spi_miso = 1'b0;
    logic [2:0] grant;
    logic       busy, timeout, spi_sck, spi_mosi, m_miso;
    logic [1:0] timeout_id;
    logic       amp_cs_n, ad_conv, dac_cs_n, spi_ss_b, sf_ce0;

    int testsRun = 0;
    int failures = 0;
    bit modelOn  = 1'b0;

    // Reference model: owner index (-1 = none), cycles owned, guard cycles left.
    int         mOwner = -1;
    int         mCnt   = 0;
    int         mGap   = 0;
    int         mRr    = 0;
    logic       mTimeout = 1'b0;
    logic [1:0] mTid     = '0;

    typedef struct {
        int         owner;
        logic [2:0] sck;
        logic [2:0] mosi;
        logic [2:0] sel;
        logic [4:0] exp;
    } vec_t;
    vec_t vecs[6];

    spi_bus_arbiter #(.GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK50MHZ   (CLK50MHZ),
        .RST        (RST),
        .req        (req),
        .done       (done),
        .m_sck      (m_sck),
        .m_mosi     (m_mosi),
        .m_sel      (m_sel),
        .grant      (grant),
        .busy       (busy),
        .timeout    (timeout),
        .timeout_id (timeout_id),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .m_miso     (m_miso),
        .amp_cs_n   (amp_cs_n),
        .ad_conv    (ad_conv),
        .dac_cs_n   (dac_cs_n),
        .spi_ss_b   (spi_ss_b),
        .sf_ce0     (sf_ce0)
    );

    always #10 CLK50MHZ = ~CLK50MHZ;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelRelease();
        mRr    = (mOwner + 1) % 3;
        mOwner = -1;
        mGap   = GUARD;
    endtask

    task automatic modelStep();
        bit found;
        int idx;
        if (RST) begin
            mOwner = -1; mCnt = 0; mGap = 0; mRr = 0; mTimeout = 1'b0; mTid = '0;
        end else begin
            mTimeout = 1'b0;
            if (mOwner >= 0) begin
                if (done[mOwner] || !req[mOwner]) begin
                    modelRelease();
                end else if (mCnt == TMO - 1) begin
                    mTimeout = 1'b1;
                    mTid     = 2'(mOwner);
                    modelRelease();
                end else begin
                    mCnt++;
                end
            end else if (mGap > 0) begin
                mGap--;
            end else begin
                found = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    idx = (mRr + k) % 3;
                    if (!found && req[idx]) begin
                        found  = 1'b1;
                        mOwner = idx;
                        mCnt   = 0;
                    end
                end
            end
        end
    endtask

    task automatic modelCheck();
        logic [2:0] eGrant;
        logic       eSck, eMosi;
        eGrant = (mOwner >= 0) ? 3'(1 << mOwner) : 3'b000;
        eSck   = (mOwner >= 0) ? m_sck[mOwner]  : 1'b0;
        eMosi  = (mOwner >= 0) ? m_mosi[mOwner] : 1'b0;
        checkOutput("mdl.grant", 32'(grant), 32'(eGrant));
        checkOutput("mdl.busy", 32'(busy), 32'((mOwner >= 0) || (mGap > 0)));
        checkOutput("mdl.timeout", 32'(timeout), 32'(mTimeout));
        checkOutput("mdl.timeout_id", 32'(timeout_id), 32'(mTid));
        checkOutput("mdl.spi_sck", 32'(spi_sck), 32'(eSck));
        checkOutput("mdl.spi_mosi", 32'(spi_mosi), 32'(eMosi));
        checkOutput("mdl.amp_cs_n", 32'(amp_cs_n), 32'(!(mOwner == 0 && m_sel[0])));
        checkOutput("mdl.ad_conv", 32'(ad_conv), 32'(mOwner == 1 && m_sel[1]));
        checkOutput("mdl.dac_cs_n", 32'(dac_cs_n), 32'(!(mOwner == 2 && m_sel[2])));
        checkOutput("mdl.m_miso", 32'(m_miso), 32'(spi_miso));
        checkOutput("mdl.spi_ss_b", 32'(spi_ss_b), 32'(1));
        checkOutput("mdl.sf_ce0", 32'(sf_ce0), 32'(1));
    endtask

    always @(posedge CLK50MHZ) modelStep();
    always @(negedge CLK50MHZ) if (modelOn) modelCheck();

    task automatic tick();
        @(posedge CLK50MHZ);
        #1;
    endtask

    task automatic doReset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    // Waits for any grant, checking the bus stays parked while none is held.
    task automatic waitGrant(input string name, input logic [2:0] expGrant, output int gap);
        bit seen;
        gap  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK50MHZ);
            if (grant != 3'b000) begin
                seen = 1'b1;
            end else begin
                gap++;
                checkOutput({name, ".idleBus"}, 32'({spi_sck, spi_mosi, amp_cs_n, ad_conv, dac_cs_n}), 32'(5'b00101));
            end
        end
        checkOutput(name, 32'(grant), 32'(expGrant));
    endtask

    task automatic releaseWithDone(input logic [2:0] who);
        tick();
        done = who;
        tick();
        done = '0;
        req  = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        tick();
        m_sck  = v.sck;
        m_mosi = v.mosi;
        m_sel  = v.sel;
        @(negedge CLK50MHZ);
        checkOutput($sformatf("table.o%0d.bus", v.owner),
                    32'({spi_sck, spi_mosi, amp_cs_n, ad_conv, dac_cs_n}), 32'(v.exp));
    endtask

    initial begin
        int         gap;
        int         owned;
        bit         held;
        logic [2:0] order[4];

        vecs[0] = '{0, 3'b001, 3'b000, 3'b001, 5'b10001};
        vecs[1] = '{0, 3'b110, 3'b111, 3'b110, 5'b01101};
        vecs[2] = '{1, 3'b010, 3'b101, 3'b010, 5'b10111};
        vecs[3] = '{1, 3'b101, 3'b010, 3'b101, 5'b01101};
        vecs[4] = '{2, 3'b100, 3'b100, 3'b100, 5'b11100};
        vecs[5] = '{2, 3'b011, 3'b011, 3'b011, 5'b00101};
        order   = '{3'b001, 3'b010, 3'b100, 3'b001};

        tick();
        modelOn = 1'b1;
        tick();
        RST = 1'b0;

        // Reset values and single-master transfer.
        @(negedge CLK50MHZ);
        checkOutput("rst.grant", 32'(grant), 32'(0));
        checkOutput("rst.busy", 32'(busy), 32'(0));
        checkOutput("rst.timeout_id", 32'(timeout_id), 32'(0));
        checkOutput("rst.bus", 32'({spi_sck, spi_mosi, amp_cs_n, ad_conv, dac_cs_n}), 32'(5'b00101));
        tick();
        req = 3'b001; m_sel = 3'b001; m_sck = 3'b001;
        @(negedge CLK50MHZ);
        checkOutput("single.latency", 32'(grant), 32'(0));
        tick();
        @(negedge CLK50MHZ);
        checkOutput("single.grant", 32'(grant), 32'(3'b001));
        checkOutput("single.amp_cs_n", 32'(amp_cs_n), 32'(0));
        checkOutput("single.sck", 32'(spi_sck), 32'(1));
        tick();
        m_sck = 3'b000; m_sel = 3'b000;
        @(negedge CLK50MHZ);
        checkOutput("single.sckLow", 32'(spi_sck), 32'(0));
        checkOutput("single.amp_cs_n_off", 32'(amp_cs_n), 32'(1));
        repeat (7) tick();
        releaseWithDone(3'b001);
        @(negedge CLK50MHZ);
        checkOutput("single.released", 32'(grant), 32'(0));
        checkOutput("single.busyG1", 32'(busy), 32'(1));
        tick();
        @(negedge CLK50MHZ);
        checkOutput("single.busyG2", 32'(busy), 32'(1));
        tick();
        @(negedge CLK50MHZ);
        checkOutput("single.busyIdle", 32'(busy), 32'(0));

        // Round-robin with all three requesting.
        tick();
        doReset();
        req = 3'b111; m_sel = 3'b111; m_sck = 3'b000; m_mosi = 3'b000;
        for (int i = 0; i < 4; i++) begin
            waitGrant($sformatf("rr.order%0d", i), order[i], gap);
            if (i > 0) checkOutput($sformatf("rr.gap%0d", i), 32'(gap), 32'(GUARD + 1));
            repeat (4) tick();
            done = order[i];
            tick();
            done = '0;
            if (i == 3) req = '0;
        end

        // Hung owner 1 is forced off; master 2 is next.
        tick();
        req = 3'b110;
        waitGrant("tmo.grant1", 3'b010, gap);
        owned = 1;
        held  = 1'b1;
        for (int i = 0; i < 40 && held; i++) begin
            @(negedge CLK50MHZ);
            if (grant == 3'b010) owned++;
            else held = 1'b0;
        end
        checkOutput("tmo.ownedCycles", 32'(owned), 32'(TMO));
        checkOutput("tmo.pulse", 32'(timeout), 32'(1));
        checkOutput("tmo.id", 32'(timeout_id), 32'(1));
        @(negedge CLK50MHZ);
        checkOutput("tmo.pulseEnd", 32'(timeout), 32'(0));
        waitGrant("tmo.next", 3'b100, gap);
        releaseWithDone(3'b100);

        // Foreign done is ignored; master 2 stays queued.
        tick();
        req = 3'b101;
        waitGrant("foreign.grant0", 3'b001, gap);
        tick();
        done = 3'b100;
        tick();
        done = '0;
        @(negedge CLK50MHZ);
        checkOutput("foreign.kept", 32'(grant), 32'(3'b001));
        tick();
        done = 3'b001;
        tick();
        done = '0;
        req  = 3'b100;
        waitGrant("foreign.queued", 3'b100, gap);
        checkOutput("foreign.gap", 32'(gap), 32'(GUARD + 1));
        releaseWithDone(3'b100);

        // done on the last allowed cycle beats the timeout.
        tick();
        req = 3'b001;
        waitGrant("race.grant", 3'b001, gap);
        repeat (15) tick();
        done = 3'b001;
        tick();
        done = '0;
        req  = '0;
        @(negedge CLK50MHZ);
        checkOutput("race.released", 32'(grant), 32'(0));
        checkOutput("race.noPulse", 32'(timeout), 32'(0));
        checkOutput("race.idKept", 32'(timeout_id), 32'(1));

        // Reset in the middle of a master 2 transfer.
        tick();
        req = 3'b100; m_sel = 3'b100; m_mosi = 3'b100;
        waitGrant("rstmid.grant", 3'b100, gap);
        checkOutput("rstmid.dac_cs_n", 32'(dac_cs_n), 32'(0));
        checkOutput("rstmid.mosi", 32'(spi_mosi), 32'(1));
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        req = 3'b111;
        @(negedge CLK50MHZ);
        checkOutput("rstmid.grant0", 32'(grant), 32'(0));
        checkOutput("rstmid.bus", 32'({spi_mosi, dac_cs_n, timeout, busy}), 32'(4'b0100));
        waitGrant("rstmid.first", 3'b001, gap);
        releaseWithDone(3'b001);

        // Bus mux vector table, one owner at a time.
        for (int o = 0; o < 3; o++) begin
            repeat (4) tick();
            req = 3'(1 << o);
            waitGrant($sformatf("table.grant%0d", o), 3'(1 << o), gap);
            for (int v = 0; v < 6; v++) begin
                if (vecs[v].owner == o) applyStimulus(vecs[v]);
            end
            releaseWithDone(3'(1 << o));
        end

        // Randomized traffic, checked every cycle against the model.
        for (int c = 0; c < 800; c++) begin
            tick();
            if ($urandom_range(0, 15) == 0) req = req ^ 3'($urandom_range(1, 7));
            done     = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            m_sck    = 3'($urandom);
            m_mosi   = 3'($urandom);
            m_sel    = 3'($urandom);
            spi_miso = 1'($urandom);
            RST      = ($urandom_range(0, 299) == 0);
        end
        tick();
        RST = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares the single board SPI bus (SCK/MOSI/MISO) between three masters: preamp gain loader (0), ADC conversion engine (1) and DAC loader (2).
- Grants exclusive ownership by round-robin and muxes the owner's SCK/MOSI onto the bus.
- Holds every non-owner device select inactive and inserts an idle guard gap between owners.
- Forces release if an owner hangs.
- Sits between the top-level sampling controller's SPI slaves and the FPGA pins.

Parameters:
- GUARD_CYCLES, 2, idle cycles between release and next grant (all selects inactive, SCK=0); legal 1..255
- TIMEOUT_CYCLES, 4096, max cycles one owner may hold the bus before forced release; legal 2..65535

Ports:
- CLK50MHZ  in  1  system clock, 50 MHz
- RST  in  1  synchronous, active-high reset
- req  in  3  bus request per master, level, held until done
- done  in  3  one-cycle transfer-complete pulse per master
- m_sck  in  3  per-master SCK
- m_mosi  in  3  per-master MOSI
- m_sel  in  3  per-master "select my device", active high
- grant  out  3  one-hot ownership, registered
- busy  out  1  high when any grant is set or a guard gap is running
- timeout  out  1  one-cycle pulse on forced release
- timeout_id  out  2  index of the last master forcibly released
- spi_sck  out  1  bus SCK
- spi_mosi  out  1  bus MOSI
- spi_miso  in  1  bus MISO
- m_miso  out  1  spi_miso broadcast to all masters, unregistered
- amp_cs_n  out  1  preamp CS, active low
- ad_conv  out  1  ADC CONV, active high
- dac_cs_n  out  1  DAC CS, active low
- spi_ss_b  out  1  platform flash select, constant 1
- sf_ce0  out  1  StrataFlash enable, constant 1

Behaviour:
- Reset values:
  - grant=000, busy=0, timeout=0, timeout_id=0
  - spi_sck=0, spi_mosi=0, amp_cs_n=1, ad_conv=0, dac_cs_n=1
  - rr pointer=0 (master 0 highest priority), state=IDLE
- FSM states: IDLE, OWNED, GUARD.
- IDLE:
  - If any req: grant the first requester found scanning from rr pointer upward, modulo 3. Go to OWNED.
  - grant is visible the cycle after req is seen (1-cycle latency).
  - No req: stay in IDLE.
- OWNED:
  - Ownership counter increments every cycle from 0.
  - Release when any of these occur: done[owner]=1, req[owner]=0, or counter==TIMEOUT_CYCLES-1.
  - On release: grant<=000, rr<=owner+1 mod 3, go to GUARD with guard counter cleared.
  - Timeout release only: timeout=1 for that release cycle edge, timeout_id<=owner.
  - If done[owner] coincides with timeout expiry: done wins, no timeout pulse.
  - done/req from non-owners are ignored; pending reqs stay queued.
- GUARD:
  - Stay exactly GUARD_CYCLES cycles, then go to IDLE.
  - New arbitration happens in IDLE, so the minimum gap between one grant falling and the next rising is GUARD_CYCLES+1 cycles.
- Bus mux, combinational from the grant register:
  - spi_sck=|(grant & m_sck), spi_mosi=|(grant & m_mosi).
  - amp_cs_n=~(grant[0]&m_sel[0]), ad_conv=grant[1]&m_sel[1], dac_cs_n=~(grant[2]&m_sel[2]).
  - With grant=000, all outputs take their reset values.
- busy = (state!=IDLE).
- RST in any state: immediate return to reset values next edge. In-flight transfer is abandoned with no timeout pulse; rr returns to 0.
- Fairness: with all three requesting continuously, grants cycle 0,1,2,0,...; no master waits more than 2 ownerships.

Decomposition:
- Shared package spi_bus_pkg:
  - master index constants (AMP=0, ADC=1, DAC=2)
  - state encoding (IDLE/OWNED/GUARD)
  - N_MASTERS=3
- One sub-module: rr_pick3 — combinational round-robin picker: req[2:0] and ptr[1:0] in, one-hot grant_next[2:0] and valid out.
- Counters and mux stay in the top module.

Test Plan:
- Reset, then req=001, hold 10 cycles, pulse done[0].
  - grant=001 one cycle after req.
  - amp_cs_n follows ~m_sel[0]; spi_sck mirrors m_sck[0].
  - After done: grant=000, busy high for 2 more cycles, then 0.
- req=111 held; each owner pulses done after 5 cycles.
  - Grant order 001,010,100,001.
  - Each gap between grants is 3 cycles with SCK=0, both CS_n=1, ad_conv=0.
- Owner 1 granted and never asserts done, TIMEOUT_CYCLES=16.
  - Release after 16 owned cycles: timeout pulse of 1 cycle, timeout_id=1, next grant goes to master 2 if requesting.
- done[2] pulsed while master 0 owns the bus.
  - Ignored; master 0 keeps grant until done[0].
  - Master 2's queued req is served after the guard gap.
- RST asserted mid-transfer while master 2 owns the bus.
  - Next edge: grant=000, dac_cs_n=1, spi_mosi=0, no timeout pulse.
  - A subsequent req=111 grants master 0 first.
- done[0] in the same cycle as timeout expiry.
  - Normal release with timeout=0; timeout_id unchanged.
